// File: rtl/dds_freq_meter_if.sv
// Sample-stream and measurement-result bundle for dds_freq_meter.
interface dds_freq_meter_if;

    logic [15:0] sample_in;
    logic        sample_en;
    logic [31:0] crossings;
    logic [31:0] step_est;
    logic [31:0] period;
    logic [15:0] peak_max;
    logic [15:0] peak_min;
    logic        result_valid;

    // Sample source / result consumer side
    modport master (
        output sample_in,
        output sample_en,
        input  crossings,
        input  step_est,
        input  period,
        input  peak_max,
        input  peak_min,
        input  result_valid
    );

    // Meter side
    modport slave (
        input  sample_in,
        input  sample_en,
        output crossings,
        output step_est,
        output period,
        output peak_max,
        output peak_min,
        output result_valid
    );

endinterface

// File: rtl/dds_freq_meter.sv
// Frequency meter for an offset-binary DDS sample stream.
// Counts rising midscale crossings (with hysteresis) over a 2^GATE_LOG2
// clock gate, so the tuning-word estimate is a shift of the crossing count.
// Also reports the most recent full period in clocks and per-window peaks.
module dds_freq_meter #(
    parameter int unsigned GATE_LOG2 = 20,
    parameter int unsigned HYST      = 256,
    parameter int unsigned MIDSCALE  = 32768
) (
    input  logic            clk,
    input  logic            reset,
    dds_freq_meter_if.slave bus
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned SHIFT    = WORD_W - GATE_LOG2;

    // Thresholds are formed in 17 bits so the sum/difference can be clamped.
    localparam logic [16:0] TH_HI_17 = 17'(MIDSCALE) + 17'(HYST);
    localparam logic [16:0] TH_LO_17 = 17'(MIDSCALE) - 17'(HYST);
    localparam logic [SAMPLE_W-1:0] TH_HI =
        (TH_HI_17 > 17'h0FFFF) ? 16'hFFFF : TH_HI_17[15:0];
    localparam logic [SAMPLE_W-1:0] TH_LO =
        (17'(HYST) > 17'(MIDSCALE)) ? 16'h0000 : TH_LO_17[15:0];

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } hyst_state_t;

    // Input stage
    logic [SAMPLE_W-1:0]  s1_sample;
    logic                 s1_en;

    // Hysteresis FSM
    hyst_state_t          state_q;
    hyst_state_t          state_d;
    logic                 event_c;

    // Window accumulators and gate
    logic [WORD_W-1:0]    cross_acc;
    logic [SAMPLE_W-1:0]  max_acc;
    logic [SAMPLE_W-1:0]  min_acc;
    logic [GATE_LOG2-1:0] gate_cnt;
    logic                 terminal_c;

    // Period measurement
    logic [WORD_W-1:0]    period_cnt;
    logic [WORD_W-1:0]    last_period;
    logic                 seen_event;

    // Next-value helpers (include any update made on the current edge)
    logic [WORD_W-1:0]    cross_next_c;
    logic [WORD_W-1:0]    period_next_c;
    logic [SAMPLE_W-1:0]  max_next_c;
    logic [SAMPLE_W-1:0]  min_next_c;

    // Registered outputs
    logic [WORD_W-1:0]    crossings_q;
    logic [WORD_W-1:0]    step_est_q;
    logic [WORD_W-1:0]    period_q;
    logic [SAMPLE_W-1:0]  peak_max_q;
    logic [SAMPLE_W-1:0]  peak_min_q;
    logic                 result_valid_q;

    // Register the incoming sample and its qualifier once
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_sample <= '0;
            s1_en     <= 1'b0;
        end else begin
            s1_sample <= bus.sample_in;
            s1_en     <= bus.sample_en;
        end
    end

    // Hysteresis state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Hysteresis next state; LOW->HIGH is the only counted crossing
    always_comb begin
        state_d = state_q;
        event_c = 1'b0;
        if (s1_en) begin
            case (state_q)
                ST_INIT: begin
                    if (s1_sample >= TH_HI) begin
                        state_d = ST_HIGH;
                    end else if (s1_sample <= TH_LO) begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (s1_sample >= TH_HI) begin
                        state_d = ST_HIGH;
                        event_c = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (s1_sample <= TH_LO) begin
                        state_d = ST_LOW;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // Window-total and period values as they stand after this edge
    always_comb begin
        terminal_c    = (gate_cnt == '1);
        cross_next_c  = cross_acc + 32'(event_c);
        period_next_c = (event_c && seen_event) ? period_cnt : last_period;
        max_next_c    = (s1_en && (s1_sample > max_acc)) ? s1_sample : max_acc;
        min_next_c    = (s1_en && (s1_sample < min_acc)) ? s1_sample : min_acc;
    end

    // Free-running saturating period counter, restarted on each crossing
    always_ff @(posedge clk) begin
        if (!reset) begin
            period_cnt  <= '0;
            last_period <= '0;
            seen_event  <= 1'b0;
        end else begin
            if (event_c) begin
                period_cnt <= 32'd1;
            end else if (period_cnt != '1) begin
                period_cnt <= period_cnt + 32'd1;
            end
            last_period <= period_next_c;
            seen_event  <= seen_event | event_c;
        end
    end

    // Gate counter; wraps at the terminal edge of each window
    always_ff @(posedge clk) begin
        if (!reset) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_LOG2'(1);
        end
    end

    // Window accumulators; cleared at the terminal edge, FSM/period carry over
    always_ff @(posedge clk) begin
        if (!reset) begin
            cross_acc <= '0;
            max_acc   <= '0;
            min_acc   <= '1;
        end else if (terminal_c) begin
            cross_acc <= '0;
            max_acc   <= '0;
            min_acc   <= '1;
        end else begin
            cross_acc <= cross_next_c;
            max_acc   <= max_next_c;
            min_acc   <= min_next_c;
        end
    end

    // Result registers load once per window and hold between pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            crossings_q    <= '0;
            step_est_q     <= '0;
            period_q       <= '0;
            peak_max_q     <= '0;
            peak_min_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= terminal_c;
            if (terminal_c) begin
                crossings_q <= cross_next_c;
                step_est_q  <= cross_next_c << SHIFT;
                period_q    <= period_next_c;
                peak_max_q  <= max_next_c;
                peak_min_q  <= min_next_c;
            end
        end
    end

    assign bus.crossings    = crossings_q;
    assign bus.step_est     = step_est_q;
    assign bus.period       = period_q;
    assign bus.peak_max     = peak_max_q;
    assign bus.peak_min     = peak_min_q;
    assign bus.result_valid = result_valid_q;

endmodule

// File: doc/dds_freq_meter.md
# dds_freq_meter

Measures the frequency of a 16-bit DDS sample stream, such as the sine generator output. It produces a 32-bit tuning-word estimate in the same units as the generator's phase step. Rising midscale crossings, with hysteresis, are counted over a power-of-two gate window, so the step estimate is a plain left shift and needs no divider. The block also reports the last full period in clocks and the min/max sample per window. It sits after the sine path in loopback, self-test and calibration.

## Interface
- GATE_LOG2, 20: gate window is 2^GATE_LOG2 clocks; legal range 4..31.
- HYST, 256: hysteresis half-band around midscale, in LSBs.
- MIDSCALE, 32768: zero level of the offset-binary input.

- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- sample_in  input  16  unsigned offset-binary sample.
- sample_en  input  1  sample_in is valid this cycle.
- crossings  output  32  rising crossings in the last completed window.
- step_est  output  32  crossings << (32-GATE_LOG2), truncated to 32 bits.
- period  output  32  clocks between the two most recent rising crossings; 0 if fewer than two since reset.
- peak_max  output  16  largest enabled sample in the last window.
- peak_min  output  16  smallest enabled sample in the last window.
- result_valid  output  1  one-cycle pulse when the outputs above update.

## Operation
- Input stage:
  - sample_in and sample_en are registered once (stage S1).
  - All decisions use the S1 values.
- Thresholds:
  - TH_HI = min(MIDSCALE+HYST, 65535); TH_LO = max(MIDSCALE-HYST, 0).
  - Both are computed in 17 bits, then clamped.
- Hysteresis FSM; states INIT, LOW, HIGH. Transitions occur only on enabled S1 samples.
  - INIT → HIGH if s ≥ TH_HI. INIT → LOW if s ≤ TH_LO. Neither transition counts as a crossing.
  - LOW → HIGH if s ≥ TH_HI. This is a rising crossing event.
  - HIGH → LOW if s ≤ TH_LO. No event.
  - Samples strictly between TH_LO and TH_HI hold the current state.
- Crossing accumulator: increments by 1 per event.
- Period counter:
  - Free-runs every clock and saturates at 0xFFFFFFFF.
  - On an event: last_period ← counter and counter ← 1, but only if an earlier event has occurred since reset. Otherwise only counter ← 1.
- Peak tracking:
  - On each enabled S1 sample, max_acc ← max(max_acc, s) and min_acc ← min(min_acc, s).
  - Window start values are max_acc = 0x0000 and min_acc = 0xFFFF. A window with no enabled samples reports 0x0000/0xFFFF.
- Gate counter:
  - GATE_LOG2 bits wide; counts every clock regardless of sample_en.
  - The terminal edge is the edge where gate_cnt = 2^GATE_LOG2−1; gate_cnt wraps to 0 there.
- At the terminal edge:
  - crossings, step_est, peak_max and peak_min load the window totals. An event or sample evaluated on that same edge is included.
  - period loads last_period, including an update made on that same edge.
  - The accumulators clear for the next window.
  - The FSM state and the period counter are NOT cleared; they carry across windows.
- Reset (reset=0 at an edge):
  - All outputs, accumulators, gate_cnt and the period counter go to 0. min_acc goes to 0xFFFF.
  - FSM goes to INIT; the "earlier event" flag clears.
  - A reset mid-window discards the partial window, and no result_valid is produced for it.

## Timing
- A sample presented at edge k is registered at k. Its FSM, peak and accumulator update happens at edge k+1.
- The first result_valid is high during the cycle after edge 2^GATE_LOG2 following reset release. It then pulses every 2^GATE_LOG2 clocks for exactly one cycle.
- Outputs are held stable between pulses.
- Max throughput: one sample per clock.
- step_est has one window of latency and a resolution of 2^(32−GATE_LOG2).
- With HYST>0, each rising crossing needs at least 2 enabled samples per cycle, so crossings ≤ 2^(GATE_LOG2−1).

## Test plan
- Use GATE_LOG2=10 and default HYST/MIDSCALE for all scenarios.
- Ideal sine, period 64 clocks (DDS step 0x04000000), sample_en=1:
  - Steady-state window → crossings=16, step_est=0x04000000, period=64.
  - peak_max/peak_min equal to the generated extremes.
- Samples alternating 32768±100 for 3 windows → crossings=0, step_est=0, period=0, peak_max=32868, peak_min=32668.
- Constant 0xFFFF from reset → FSM stays in HIGH and crossings=0 every window. Then a drop to 0x0000 and a return to 0xFFFF produces exactly 1 crossing in that window.
- Period-64 sine with sample_en toggling every other clock (effective period 128 clocks) → crossings=8, step_est=0x02000000, period=128.
- Assert reset for 1 cycle at gate_cnt=500:
  - All outputs read 0 immediately after.
  - No result_valid for the aborted window.
  - The next result_valid comes 1024 clocks after reset release.
- Square wave 0x0000/0xFFFF with half-period 1 clock:
  - crossings=512, step_est=0x80000000, period=2.
  - A crossing on the terminal edge is counted in the closing window.
